// File: rtl/serial_addsub_ctrl.sv
// Serial WIDTH-bit adder/subtractor: one 4-bit two's-complement slice stepped LSB-first,
// with the inter-nibble carry held in a register. Start/result valid/ready handshakes.
module serial_addsub_ctrl #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES,
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mode,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and an offered result stays stable until it is taken.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [3:0] a_nib, b_nib;
  logic [3:0] sum_nib;
  logic       cout;
  logic       c_msb_in;
  logic       last_nib;

  // Slice; c_msb_in is the carry into bit 3, needed for the true signed overflow.
  always_comb begin
    a_nib = a_q[4*idx +: 4];
    b_nib = b_q[4*idx +: 4] ^ {4{mode_q}};
    {cout, sum_nib} = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry_q};
    c_msb_in = 1'(({1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'd0, carry_q}) >> 3);
    last_nib = (idx == IDX_W'(NIBBLES - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid)  state_nxt = CALC;
      CALC:    if (last_nib)     state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      idx      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q     <= op_a;
            b_q     <= op_b;
            mode_q  <= mode;
            carry_q <= mode;
            idx     <= '0;
          end
        end
        CALC: begin
          result[4*idx +: 4] <= sum_nib;
          carry_q            <= cout;
          idx                <= idx + 1'b1;
          if (last_nib) begin
            carry    <= cout;
            overflow <= cout ^ c_msb_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready  = rst_n && (state == IDLE);
  assign result_valid = (state == DONE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl: arithmetic model, per-cycle compare against
// an expected queue, latency/backpressure/reset checks, single summary line.
module tb_serial_addsub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a, op_b;
  logic         mode;
  logic         result_valid;
  logic         result_ready;
  logic [W-1:0] result;
  logic         carry, overflow;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  logic [W+1:0] exp_q[$];   // {carry, overflow, result}

  serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .mode(mode),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .carry(carry), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Model: plain integer arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m);
    longint ua, ub, sa, sb, ur, sr;
    logic c, o;
    logic [W-1:0] r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur >= (64'sd1 <<< W));
    end
    r = W'(ur);
    o = (sr > ((64'sd1 <<< (W - 1)) - 1)) || (sr < -(64'sd1 <<< (W - 1)));
    return {c, o, r};
  endfunction

  // compare process: outputs must match the head of the queue whenever valid
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", {carry, overflow, result}, '1);
      else                   check("result_cmp", {carry, overflow, result}, exp_q[0]);
    end
  end

  always @(posedge clk) begin
    if (rst_n && result_valid && result_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  // driver: one operation, optional backpressure cycles while DONE
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic [W-1:0] er, input logic ec, input logic eo,
                       input int hold);
    int n;
    logic [W+1:0] e;
    e = model(a, b, m);
    check("model_pin", e, {ec, eo, er});
    @(posedge clk); #1;
    start_valid = 1'b1; op_a = a; op_b = b; mode = m;
    n = 0;
    while (!start_ready && n < 20) begin @(posedge clk); #1; n++; end
    check("start_ready_wait", 34'(start_ready), 34'(1));
    exp_q.push_back(e);
    @(posedge clk); #1;                       // accept edge
    start_valid = 1'b0;
    op_a = W'($urandom_range(0, 65535));
    op_b = W'($urandom_range(0, 65535));
    mode = ~m;
    n = 0;
    while (!result_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", 34'(n), 34'(NIBBLES));
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 34'(result_valid), 34'(1));
      check("hold_start_ready", 34'(start_ready), 34'(0));
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    check("drop_valid", 34'(result_valid), 34'(0));
    check("idle_ready", 34'(start_ready), 34'(1));
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0;
    op_a = '0; op_b = '0; mode = 1'b0;
    #1;
    check("ready_in_reset", 34'(start_ready), 34'(0));
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {carry, overflow, result}, '0);
    check("reset_valid", 34'(result_valid), 34'(0));
    rst_n = 1'b1;
    #1;
    check("reset_ready", 34'(start_ready), 34'(1));

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
    do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    do_op(16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 0);
    do_op(16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    do_op(16'h3C5A, 16'h0F0F, 1'b1, 16'h2D4B, 1'b1, 1'b0, 5);

    // reset two nibbles into CALC
    @(posedge clk); #1;
    start_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; mode = 1'b0;
    @(posedge clk); #1;                       // accepted (IDLE, ready)
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check("abort_outputs", {carry, overflow, result}, '0);
    check("abort_valid", 34'(result_valid), 34'(0));
    check("abort_state", 34'(dbg_state), 34'(0));
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_result", 34'(result_valid), 34'(0));
    end
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("queue_drained", 34'(exp_q.size()), 34'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
